// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destination registers from X to W and
// derives operand forwarding selects, load-use/no-forward stalls and a stall-cycle counter.
module hazard_scoreboard #(
   parameter int NUM_STAGES = 3,
   parameter int REG_ADDR_W = 5,
   parameter int FWD_EN     = 1,
   parameter int LOAD_STAGE = 1,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  d_valid_i,
   input  logic [REG_ADDR_W-1:0] d_rs1_i,
   input  logic                  d_rs1_used_i,
   input  logic [REG_ADDR_W-1:0] d_rs2_i,
   input  logic                  d_rs2_used_i,
   input  logic [REG_ADDR_W-1:0] d_rd_i,
   input  logic                  d_wen_i,
   input  logic                  d_is_load_i,
   input  logic                  flush_i,
   input  logic                  ext_stall_i,
   output logic                  issue_o,
   output logic                  stall_o,
   output logic [SEL_W-1:0]      rs1_fwd_sel_o,
   output logic [SEL_W-1:0]      rs2_fwd_sel_o,
   output logic [NUM_STAGES-1:0] stage_valid_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   logic [NUM_STAGES-1:0] st_valid;
   logic [NUM_STAGES-1:0] st_wen;
   logic [NUM_STAGES-1:0] st_load;
   logic [REG_ADDR_W-1:0] st_rd [NUM_STAGES];
   logic [CNT_W-1:0]      stall_cnt;

   logic [REG_ADDR_W-1:0] src [2];
   logic [1:0]            src_used;
   logic [SEL_W-1:0]      sel [2];
   logic                  hazard;
   logic                  hit;
   logic                  hit_load;
   int                    hit_k;
   logic                  hz;
   logic                  hz_stall;

   assign src[0]      = d_rs1_i;
   assign src[1]      = d_rs2_i;
   assign src_used[0] = d_rs1_used_i;
   assign src_used[1] = d_rs2_used_i;

   // Youngest-match search per source operand; scanning old to young lets the youngest overwrite.
   always_comb begin
      hazard   = 1'b0;
      hit      = 1'b0;
      hit_load = 1'b0;
      hit_k    = 0;
      hz       = 1'b0;
      sel[0]   = {SEL_W{1'b0}};
      sel[1]   = {SEL_W{1'b0}};
      for (int s = 0; s < 2; s++) begin
         hit      = 1'b0;
         hit_load = 1'b0;
         hit_k    = 0;
         for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (src_used[s] && (src[s] != {REG_ADDR_W{1'b0}}) && st_valid[k] && st_wen[k]
                && (st_rd[k] == src[s])) begin
               hit      = 1'b1;
               hit_load = st_load[k];
               hit_k    = k;
            end else begin
               hit      = hit;
            end
         end
         if (FWD_EN == 0) begin
            hz = hit;
         end else begin
            hz = hit & hit_load & (hit_k < LOAD_STAGE);
         end
         hazard = hazard | hz;
         if (hit && !hz) begin
            sel[s] = SEL_W'(hit_k + 1);
         end else begin
            sel[s] = {SEL_W{1'b0}};
         end
      end
   end

   // A flushed decode slot is discarded, so it never counts as a hazard stall.
   assign hz_stall      = d_valid_i & hazard & ~flush_i;
   assign issue_o       = ~ext_stall_i & d_valid_i & ~hazard & ~flush_i;
   assign stall_o       = ext_stall_i | hz_stall;
   assign rs1_fwd_sel_o = sel[0];
   assign rs2_fwd_sel_o = sel[1];
   assign stage_valid_o = st_valid;
   assign stall_cnt_o   = stall_cnt;

   // Scoreboard shift register and saturating stall counter; everything freezes on ext_stall_i.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         st_valid  <= {NUM_STAGES{1'b0}};
         st_wen    <= {NUM_STAGES{1'b0}};
         st_load   <= {NUM_STAGES{1'b0}};
         stall_cnt <= {CNT_W{1'b0}};
         for (int k = 0; k < NUM_STAGES; k++) begin
            st_rd[k] <= {REG_ADDR_W{1'b0}};
         end
      end else if (!ext_stall_i) begin
         for (int k = NUM_STAGES - 1; k > 0; k--) begin
            st_valid[k] <= st_valid[k-1];
            st_wen[k]   <= st_wen[k-1];
            st_load[k]  <= st_load[k-1];
            st_rd[k]    <= st_rd[k-1];
         end
         st_valid[0] <= issue_o;
         st_wen[0]   <= issue_o & d_wen_i;
         st_load[0]  <= issue_o & d_is_load_i;
         st_rd[0]    <= issue_o ? d_rd_i : {REG_ADDR_W{1'b0}};
         if (hz_stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt <= stall_cnt;
         end
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: three parameter variants share one stimulus bus;
// each vector names the instance whose outputs the monitor checks.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       d_valid = 1'b0;
   logic [4:0] d_rs1 = 5'd0;
   logic       d_rs1_used = 1'b0;
   logic [4:0] d_rs2 = 5'd0;
   logic       d_rs2_used = 1'b0;
   logic [4:0] d_rd = 5'd0;
   logic       d_wen = 1'b0;
   logic       d_is_load = 1'b0;
   logic       flush = 1'b0;
   logic       ext_stall = 1'b0;

   logic        issue [3];
   logic        stall [3];
   logic [1:0]  s1 [3];
   logic [1:0]  s2 [3];
   logic [2:0]  sv [3];
   logic [15:0] cnt [3];

   typedef struct {
      int          dut;
      logic [24:0] val;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   hazard_scoreboard u_def (
      .clk_i(clk), .rst_n_i(rst_n), .d_valid_i(d_valid), .d_rs1_i(d_rs1),
      .d_rs1_used_i(d_rs1_used), .d_rs2_i(d_rs2), .d_rs2_used_i(d_rs2_used), .d_rd_i(d_rd),
      .d_wen_i(d_wen), .d_is_load_i(d_is_load), .flush_i(flush), .ext_stall_i(ext_stall),
      .issue_o(issue[0]), .stall_o(stall[0]), .rs1_fwd_sel_o(s1[0]), .rs2_fwd_sel_o(s2[0]),
      .stage_valid_o(sv[0]), .stall_cnt_o(cnt[0]));

   hazard_scoreboard #(.LOAD_STAGE(2)) u_ls2 (
      .clk_i(clk), .rst_n_i(rst_n), .d_valid_i(d_valid), .d_rs1_i(d_rs1),
      .d_rs1_used_i(d_rs1_used), .d_rs2_i(d_rs2), .d_rs2_used_i(d_rs2_used), .d_rd_i(d_rd),
      .d_wen_i(d_wen), .d_is_load_i(d_is_load), .flush_i(flush), .ext_stall_i(ext_stall),
      .issue_o(issue[1]), .stall_o(stall[1]), .rs1_fwd_sel_o(s1[1]), .rs2_fwd_sel_o(s2[1]),
      .stage_valid_o(sv[1]), .stall_cnt_o(cnt[1]));

   hazard_scoreboard #(.FWD_EN(0)) u_nofwd (
      .clk_i(clk), .rst_n_i(rst_n), .d_valid_i(d_valid), .d_rs1_i(d_rs1),
      .d_rs1_used_i(d_rs1_used), .d_rs2_i(d_rs2), .d_rs2_used_i(d_rs2_used), .d_rd_i(d_rd),
      .d_wen_i(d_wen), .d_is_load_i(d_is_load), .flush_i(flush), .ext_stall_i(ext_stall),
      .issue_o(issue[2]), .stall_o(stall[2]), .rs1_fwd_sel_o(s1[2]), .rs2_fwd_sel_o(s2[2]),
      .stage_valid_o(sv[2]), .stall_cnt_o(cnt[2]));

   // Monitor: outputs are settled mid-cycle; compare against the oldest queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [24:0] got;
         e   = exp_q.pop_front();
         got = {issue[e.dut], stall[e.dut], s1[e.dut], s2[e.dut], sv[e.dut], cnt[e.dut]};
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL %s: got iss=%b stl=%b s1=%0d s2=%0d sv=%b cnt=%0d, need iss=%b stl=%b s1=%0d s2=%0d sv=%b cnt=%0d",
                     e.tag, got[24], got[23], got[22:21], got[20:19], got[18:16], got[15:0],
                     e.val[24], e.val[23], e.val[22:21], e.val[20:19], e.val[18:16], e.val[15:0]);
         end
      end
   end

   // One cycle: drive decode inputs just after the edge and queue the hand-computed response.
   task automatic step(input int dut, input logic rst, input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic wen,
                       input logic ld, input logic fl, input logic es,
                       input logic e_iss, input logic e_stl, input logic [1:0] e_s1,
                       input logic [1:0] e_s2, input logic [2:0] e_sv, input logic [15:0] e_cnt,
                       input string tag);
      exp_t e;
      rst_n = rst; d_valid = v; d_rs1 = rs1; d_rs1_used = v; d_rs2 = rs2; d_rs2_used = v;
      d_rd = rd; d_wen = wen; d_is_load = ld; flush = fl; ext_stall = es;
      e.dut = dut;
      e.val = {e_iss, e_stl, e_s1, e_s2, e_sv, e_cnt};
      e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int dut);
      step(dut, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 16'd0, "reset");
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset state, and an external stall on an empty scoreboard
      do_reset(0);
      step(0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 3'b000, 16'd0, "empty_ext_stall");
      // Forwarding distance from X, M and W, then retired producer
      step(0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 16'd0, "t1_prod_x5");
      step(0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 3'b001, 16'd0, "t1_fwd_x");
      step(0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2, 3'b011, 16'd0, "t1_fwd_m");
      step(0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 3'b111, 16'd0, "t1_fwd_w");
      step(0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b111, 16'd0, "t1_retired");
      // Load-use, LOAD_STAGE = 1
      do_reset(0);
      step(0, 1'b1, 1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 16'd0, "t2_lw");
      step(0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'b001, 16'd0, "t2_loaduse");
      step(0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 3'b010, 16'd1, "t2_issue");
      step(0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'b101, 16'd1, "t2_after");
      // Load-use, LOAD_STAGE = 2
      do_reset(1);
      step(1, 1'b1, 1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 16'd0, "t2b_lw");
      step(1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'b001, 16'd0, "t2b_stall1");
      step(1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'b010, 16'd1, "t2b_stall2");
      step(1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 3'b100, 16'd2, "t2b_issue");
      // No forwarding: wait for producer to retire past W
      do_reset(2);
      step(2, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 16'd0, "t3_prod_x3");
      step(2, 1'b1, 1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'b001, 16'd0, "t3_stall_x");
      step(2, 1'b1, 1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'b010, 16'd1, "t3_stall_m");
      step(2, 1'b1, 1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'b100, 16'd2, "t3_stall_w");
      step(2, 1'b1, 1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 16'd3, "t3_issue");
      // Youngest match wins; x0 is never a hazard
      do_reset(0);
      step(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 16'd0, "t4_x9_old");
      step(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b001, 16'd0, "t4_x10");
      step(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b011, 16'd0, "t4_x9_new");
      step(0, 1'b1, 1'b1, 5'd9, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 3'b111, 16'd0, "t4_youngest");
      step(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b111, 16'd0, "t4_wr_x0");
      step(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b111, 16'd0, "t4_rd_x0");
      // Flush overrides a pending load-use stall
      do_reset(0);
      step(0, 1'b1, 1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 16'd0, "t5_lw");
      step(0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'b001, 16'd0, "t5_flush");
      step(0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'b010, 16'd0, "t5_bubble");
      // External stall freezes everything; reset mid-stall clears at once
      do_reset(0);
      step(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 16'd0, "t6_i1");
      step(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b001, 16'd0, "t6_i2");
      for (int i = 0; i < 4; i++) begin
         step(0, 1'b1, 1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 3'b011, 16'd0, "t6_ext_hold");
      end
      step(0, 1'b0, 1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 3'b000, 16'd0, "t6_rst_mid");
      step(0, 1'b1, 1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 16'd0, "t6_post_rst");
      step(0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'b001, 16'd0, "t6_issued");
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline control hazard logic.
- Tracks destination registers of every in-flight instruction from X through W in a per-stage scoreboard shift register.
- Generates per-operand forwarding selects, load-use stalls, flush bubbles and a saturating stall-cycle counter.
- Sits between decode and the operand bypass muxes. The datapath supplies one result bus per stage; this block only chooses among them.

Parameters:
- NUM_STAGES, 3, in-flight stages after decode. Stage 0 = X, stage NUM_STAGES-1 = W (register-file write at end of cycle).
- REG_ADDR_W, 5, register address width. Address 0 is hardwired zero and never a hazard.
- FWD_EN, 1, forwarding control. 1 = forward when legal; 0 = stall on any match, fwd selects forced to 0.
- LOAD_STAGE, 1, lowest stage index whose result bus carries valid load data.
- CNT_W, 16, stall counter width.
- SEL_W (localparam) = $clog2(NUM_STAGES+1).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- d_valid_i  in  1  decode holds a valid instruction
- d_rs1_i  in  REG_ADDR_W  source 1 address
- d_rs1_used_i  in  1  source 1 is read
- d_rs2_i  in  REG_ADDR_W  source 2 address
- d_rs2_used_i  in  1  source 2 is read
- d_rd_i  in  REG_ADDR_W  destination address
- d_wen_i  in  1  instruction writes rd
- d_is_load_i  in  1  instruction is a load
- flush_i  in  1  taken branch/jump resolved in X; kill decode
- ext_stall_i  in  1  memory not ready; freeze whole pipeline
- issue_o  out  1  decode instruction enters X this cycle
- stall_o  out  1  hold PC and decode register
- rs1_fwd_sel_o  out  SEL_W  0 = register file, k = stage k-1 result
- rs2_fwd_sel_o  out  SEL_W  as rs1
- stage_valid_o  out  NUM_STAGES  per-stage occupancy
- stall_cnt_o  out  CNT_W  hazard stall cycles since reset

Behaviour:
Reset (asynchronous, active-low):
- All stage entries cleared: valid, wen, is_load = 0; rd = 0.
- stall_cnt_o = 0, stage_valid_o = 0.
- With an empty scoreboard: stall_o = ext_stall_i, and fwd selects = 0.

Scoreboard entry per stage: {valid, wen, rd, is_load}.

Match for source s (rs1 or rs2):
- Requires s_used = 1 and s != 0.
- Requires a stage k with valid & wen & rd == s.
- The youngest match (smallest k) wins.

Hazard for source s (all combinational from current state and decode inputs):
- FWD_EN = 0: any match.
- FWD_EN = 1: youngest match is_load and k < LOAD_STAGE.
- Otherwise no hazard; fwd_sel = k+1 on a match, 0 with no match.
- hazard = hz1 | hz2.

Outputs:
- issue_o = ~ext_stall_i & d_valid_i & ~hazard & ~flush_i.
- stall_o = ext_stall_i | (d_valid_i & hazard & ~flush_i). Flush overrides hazard, because the decode instruction is discarded anyway.

Sequential update, ext_stall_i = 1:
- All entries hold.
- flush_i is ignored; the source holds it until ext_stall_i drops.
- Counter holds.

Sequential update, ext_stall_i = 0:
- stage[k+1] <= stage[k] for all k; the old W entry retires.
- stage[0] <= issue_o ? {1, d_wen_i, d_rd_i, d_is_load_i} : bubble (all zero).
- Hazard stall and flush both inject a bubble.

Stall counter:
- Increments when ext_stall_i = 0 & d_valid_i & hazard & ~flush_i.
- Saturates at all-ones and never wraps.

Other rules:
- Register file is not write-through, so a W-stage match must forward (FWD_EN = 1) or stall (FWD_EN = 0).
- Reset mid-stall clears the scoreboard immediately. The stalled decode instruction issues on the first cycle after reset release, provided it is still presented.

Test Plan (defaults unless noted):
1. add x5 issued, next cycle add x6,x5,x5 -> no stall; rs1_fwd_sel_o = rs2_fwd_sel_o = 1. Then the same consumer two cycles later -> sel = 2; three cycles later -> sel = 3.
2. lw x7 issued, then add x8,x7,x0 -> stall_o = 1 for exactly 1 cycle, stall_cnt_o 0 -> 1. Next cycle issue_o = 1 with rs1_fwd_sel_o = 2. Repeat with LOAD_STAGE = 2 -> 2 stall cycles, count = 2, then sel = 3.
3. FWD_EN = 0: add x3, then sub x4,x3,x1 -> 3 stall cycles (X, M, W occupancy). Issue on the 4th cycle with sel = 0.
4. Producer of x9 in X, rd x9 also in W, consumer reads x9 -> sel = 1 (youngest wins). Consumer reading x0 behind a write to x0 -> sel = 0, no stall.
5. Load-use hazard pending while flush_i = 1 -> stall_o = 0, issue_o = 0, stage 0 becomes a bubble, counter unchanged.
6. ext_stall_i = 1 for 4 cycles with stage_valid_o = 3'b011 -> stage_valid_o holds 3'b011, issue_o = 0, counter unchanged. Assert rst_n_i low mid-sequence -> stage_valid_o = 0 and stall_cnt_o = 0 immediately.
